// File: rtl/abs_diff_pkg.sv
// Shared definitions for the streaming SAD engine.
//   state_e    : block FSM states
//   sad_width  : accumulator width needed for a block of operands
//   trunc_mask : operand mask that zeroes the low TRUNC bits
package abs_diff_pkg;

  localparam int unsigned MaxWidth = 63;

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StFlush,
    StHold
  } state_e;

  // Worst-case block sum is BLOCK_LEN * (2**WIDTH - 1); one spare bit keeps it clear of the top.
  function automatic int unsigned sad_width(input int unsigned width,
                                            input int unsigned block_len);
    return width + $clog2(block_len) + 1;
  endfunction

  // Ones in bits [width-1:trunc], zeros elsewhere.
  function automatic logic [63:0] trunc_mask(input int unsigned width, input int unsigned trunc);
    logic [63:0] keep;
    logic [63:0] low;
    keep = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    low  = (64'd1 << trunc) - 64'd1;
    return keep & ~low;
  endfunction

endpackage

// File: rtl/abs_diff_sad_stream_if.sv
// Operand/result bus of the SAD engine.
//   in_valid/in_ready/in_a/in_b/approx_en : operand stream (source -> engine)
//   out_valid/out_ready/out_sad/out_approx : block result (engine -> consumer)
//   out_err/out_err_over                   : accuracy monitor outputs
// master: operand source / result consumer side; slave: the engine.
interface abs_diff_sad_stream_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SAD_W = 11
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             approx_en;
  logic             out_valid;
  logic             out_ready;
  logic [SAD_W-1:0] out_sad;
  logic             out_approx;
  logic [SAD_W-1:0] out_err;
  logic             out_err_over;

  modport master (
    output in_valid, in_a, in_b, approx_en, out_ready,
    input  in_ready, out_valid, out_sad, out_approx, out_err, out_err_over
  );

  modport slave (
    input  in_valid, in_a, in_b, approx_en, out_ready,
    output in_ready, out_valid, out_sad, out_approx, out_err, out_err_over
  );
endinterface

// File: rtl/abs_diff_stage.sv
// Registered absolute difference |a' - b'| with optional LSB truncation.
//   clk, rst : clock, asynchronous active-high reset
//   i_valid  : operands are a new beat
//   i_trunc  : zero the low TRUNC bits of both operands
//   i_a, i_b : unsigned operands
//   o_valid  : o_diff holds a beat registered on the previous edge
//   o_diff   : WIDTH-bit magnitude of the difference
module abs_diff_stage
  import abs_diff_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned TRUNC = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  input  logic             i_trunc,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_diff
);

  localparam logic [63:0]      MaskFull = trunc_mask(WIDTH, TRUNC);
  localparam logic [WIDTH-1:0] Mask     = MaskFull[WIDTH-1:0];

  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_sub;
  logic             w_borrow;
  logic [WIDTH-1:0] w_mag;
  logic             r_valid;
  logic [WIDTH-1:0] r_diff;

  always_comb begin
    w_a = i_a;
    w_b = i_b;
    if (i_trunc) begin
      w_a = i_a & Mask;
      w_b = i_b & Mask;
    end
    // WIDTH+1-bit subtract; the borrow is the sign. When negative, the low WIDTH
    // bits are a-b+2**WIDTH, so their two's complement is exactly b-a.
    {w_borrow, w_sub} = {1'b0, w_a} - {1'b0, w_b};
    w_mag = w_borrow ? -w_sub : w_sub;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_diff  <= '0;
    end else begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_diff <= w_mag;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_diff  = r_diff;

endmodule

// File: rtl/abs_diff_sad_stream.sv
// Streaming sum-of-absolute-differences engine: accepts one operand pair per beat,
// accumulates |a-b| over BLOCK_LEN beats and presents one SAD per block.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : abs_diff_sad_stream_if.slave (operand stream, result, monitor)
// Optional build macro ABS_DIFF_ERR_MON_EN adds an exact-mode shadow path whose
// difference from the delivered SAD drives out_err/out_err_over; without it those
// outputs are tied to 0.
module abs_diff_sad_stream
  import abs_diff_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned BLOCK_LEN  = 4,
  parameter int unsigned TRUNC      = 2,
  parameter int unsigned ERR_THRESH = 4,
  parameter int unsigned SAD_W      = sad_width(WIDTH, BLOCK_LEN)
) (
  input logic                 clk,
  input logic                 rst,
  abs_diff_sad_stream_if.slave bus
);

  localparam int unsigned     CntW    = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(BLOCK_LEN - 1);
  localparam logic [CntW-1:0] OneCnt  = CntW'(1);

  if (WIDTH < 1 || WIDTH > MaxWidth) begin : g_bad_width
    $error("WIDTH must be in 1..63");
  end
  if (BLOCK_LEN < 1) begin : g_bad_block_len
    $error("BLOCK_LEN must be >= 1");
  end
  if (TRUNC >= WIDTH) begin : g_bad_trunc
    $error("TRUNC must be < WIDTH");
  end
  if (SAD_W < sad_width(WIDTH, BLOCK_LEN)) begin : g_bad_sad_w
    $error("SAD_W too narrow for the block sum");
  end
  if (SAD_W < 32 && 64'(ERR_THRESH) >= (64'd1 << SAD_W)) begin : g_bad_thresh
    $error("ERR_THRESH not representable in SAD_W bits");
  end

  state_e           r_state;
  logic [CntW-1:0]  r_cnt;
  logic             r_mode;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [SAD_W-1:0] r_acc;

  logic             w_in_hs;
  logic             w_out_hs;
  logic             w_trunc;
  logic             w_d_valid;
  logic [WIDTH-1:0] w_d;
  logic [SAD_W-1:0] w_acc_next;

  assign w_in_hs  = bus.in_valid & r_in_ready;
  assign w_out_hs = r_out_valid & bus.out_ready;
  // The first beat of a block uses approx_en directly; later beats use the latched mode.
  assign w_trunc  = (r_state == StIdle) ? bus.approx_en : r_mode;

  abs_diff_stage #(
    .WIDTH (WIDTH),
    .TRUNC (TRUNC)
  ) u_stage (
    .clk     (clk),
    .rst     (rst),
    .i_valid (w_in_hs),
    .i_trunc (w_trunc),
    .i_a     (bus.in_a),
    .i_b     (bus.in_b),
    .o_valid (w_d_valid),
    .o_diff  (w_d)
  );

  assign w_acc_next = r_acc + {{(SAD_W - WIDTH){1'b0}}, w_d};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
    end else if (w_out_hs) begin
      r_acc <= '0;
    end else if (w_d_valid) begin
      r_acc <= w_acc_next;
    end
  end

  // Block FSM; in_ready and out_valid are registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_mode      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_in_hs) begin
            r_mode <= bus.approx_en;
            if (BLOCK_LEN == 1) begin
              r_state    <= StFlush;
              r_in_ready <= 1'b0;
            end else begin
              r_cnt   <= OneCnt;
              r_state <= StAccum;
            end
          end
        end
        StAccum: begin
          if (w_in_hs) begin
            if (r_cnt == LastCnt) begin
              r_cnt      <= '0;
              r_state    <= StFlush;
              r_in_ready <= 1'b0;
            end else begin
              r_cnt <= r_cnt + OneCnt;
            end
          end
        end
        StFlush: begin
          r_state     <= StHold;
          r_out_valid <= 1'b1;
        end
        StHold: begin
          if (bus.out_ready) begin
            r_state     <= StIdle;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= StIdle;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready   = r_in_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_sad    = r_acc;
  assign bus.out_approx = r_mode;

`ifdef ABS_DIFF_ERR_MON_EN
  localparam logic [SAD_W-1:0] Thresh = SAD_W'(ERR_THRESH);

  logic             w_dx_valid;
  logic [WIDTH-1:0] w_dx;
  logic [SAD_W-1:0] w_accx_next;
  logic [SAD_W-1:0] w_err;
  logic [SAD_W-1:0] r_accx;
  logic [SAD_W-1:0] r_err;
  logic             r_err_over;

  // Shadow path always runs exact, fed by the same accepted beats.
  abs_diff_stage #(
    .WIDTH (WIDTH),
    .TRUNC (TRUNC)
  ) u_stage_exact (
    .clk     (clk),
    .rst     (rst),
    .i_valid (w_in_hs),
    .i_trunc (1'b0),
    .i_a     (bus.in_a),
    .i_b     (bus.in_b),
    .o_valid (w_dx_valid),
    .o_diff  (w_dx)
  );

  assign w_accx_next = r_accx + {{(SAD_W - WIDTH){1'b0}}, w_dx};
  assign w_err       = (w_accx_next >= w_acc_next) ? (w_accx_next - w_acc_next)
                                                   : (w_acc_next - w_accx_next);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_accx     <= '0;
      r_err      <= '0;
      r_err_over <= 1'b0;
    end else if (w_out_hs) begin
      r_accx     <= '0;
      r_err      <= '0;
      r_err_over <= 1'b0;
    end else begin
      if (w_dx_valid) begin
        r_accx <= w_accx_next;
      end
      // Both paths take their last difference during FLUSH, so the final sums
      // are the next-state values there.
      if (r_state == StFlush) begin
        r_err      <= w_err;
        r_err_over <= (w_err > Thresh);
      end
    end
  end

  assign bus.out_err      = r_err;
  assign bus.out_err_over = r_err_over;
`else
  assign bus.out_err      = '0;
  assign bus.out_err_over = 1'b0;
`endif

endmodule

// File: tb/tb_abs_diff_sad_stream.sv
module tb_abs_diff_sad_stream;
  localparam int unsigned W  = 8;
  localparam int unsigned BL = 4;
  localparam int unsigned TR = 2;
  localparam int unsigned TH = 4;
  localparam int unsigned SW = 11;
`ifdef ABS_DIFF_ERR_MON_EN
  localparam bit MonEn = 1'b1;
`else
  localparam bit MonEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  abs_diff_sad_stream_if #(.WIDTH(W), .SAD_W(SW)) bus ();

  abs_diff_sad_stream #(
    .WIDTH      (W),
    .BLOCK_LEN  (BL),
    .TRUNC      (TR),
    .ERR_THRESH (TH),
    .SAD_W      (SW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] ga[BL];
  logic [7:0] gb[BL];
  bit         gm[BL];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // SAD of the current block, straight from the definition.
  function automatic int ref_sad(input bit approx);
    int s;
    s = 0;
    for (int i = 0; i < BL; i++) begin
      int ta;
      int tb;
      int d;
      ta = int'(ga[i]);
      tb = int'(gb[i]);
      if (approx) begin
        ta = (ta >> TR) << TR;
        tb = (tb >> TR) << TR;
      end
      d = ta - tb;
      if (d < 0) d = -d;
      s += d;
    end
    return s;
  endfunction

  task automatic send_block(input bit gaps);
    for (int i = 0; i < BL; i++) begin
      bus.in_valid  = 1'b1;
      bus.in_a      = ga[i];
      bus.in_b      = gb[i];
      bus.approx_en = gm[i];
      if (!bus.in_ready) chk("in_ready_before_beat", 32'(bus.in_ready), 1);
      step();
      if (gaps && i != BL - 1) begin
        bus.in_valid  = 1'b0;
        bus.in_a      = 8'($urandom);
        bus.in_b      = 8'($urandom);
        bus.approx_en = 1'($urandom);
        step();
      end
    end
    bus.in_valid = 1'b0;
  endtask

  // Called right after the edge that accepted the last beat.
  task automatic finish_block(input string name, input int hold);
    int exact;
    int got;
    int err;
    int over;
    exact = ref_sad(1'b0);
    got   = ref_sad(gm[0]);
    err   = (exact > got) ? exact - got : got - exact;
    if (!MonEn) err = 0;
    over  = (MonEn && err > int'(TH)) ? 1 : 0;
    chk({name, ".valid_flush"}, 32'(bus.out_valid), 0);
    chk({name, ".ready_flush"}, 32'(bus.in_ready), 0);
    step();
    chk({name, ".valid"},    32'(bus.out_valid), 1);
    chk({name, ".sad"},      32'(bus.out_sad), got);
    chk({name, ".approx"},   32'(bus.out_approx), 32'(gm[0]));
    chk({name, ".err"},      32'(bus.out_err), err);
    chk({name, ".err_over"}, 32'(bus.out_err_over), over);
    for (int k = 0; k < hold; k++) begin
      bus.in_valid = 1'b1;
      bus.in_a     = 8'($urandom);
      bus.in_b     = 8'($urandom);
      step();
      chk({name, ".hold_valid"}, 32'(bus.out_valid), 1);
      chk({name, ".hold_sad"},   32'(bus.out_sad), got);
      chk({name, ".hold_ready"}, 32'(bus.in_ready), 0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk({name, ".valid_done"}, 32'(bus.out_valid), 0);
    chk({name, ".ready_done"}, 32'(bus.in_ready), 1);
  endtask

  task automatic set_pairs(input int a0, b0, a1, b1, a2, b2, a3, b3, input bit m0, mr);
    ga[0] = 8'(a0); gb[0] = 8'(b0);
    ga[1] = 8'(a1); gb[1] = 8'(b1);
    ga[2] = 8'(a2); gb[2] = 8'(b2);
    ga[3] = 8'(a3); gb[3] = 8'(b3);
    gm[0] = m0; gm[1] = mr; gm[2] = mr; gm[3] = mr;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.approx_en = 1'b0;
    bus.out_ready = 1'b0;
    step();
    step();
    chk("rst.in_ready",  32'(bus.in_ready), 1);
    chk("rst.out_valid", 32'(bus.out_valid), 0);
    chk("rst.out_sad",   32'(bus.out_sad), 0);
    chk("rst.approx",    32'(bus.out_approx), 0);
    chk("rst.err",       32'(bus.out_err), 0);
    chk("rst.err_over",  32'(bus.out_err_over), 0);
    rst = 1'b0;
    step();

    // Exact block
    set_pairs(10, 3, 3, 10, 255, 0, 7, 7, 1'b0, 1'b0);
    send_block(1'b0);
    finish_block("t1", 0);

    // Approximate, within threshold
    set_pairs(13, 2, 6, 5, 1, 2, 8, 8, 1'b1, 1'b1);
    send_block(1'b0);
    finish_block("t2", 0);

    // Approximate, over threshold
    set_pairs(3, 0, 3, 0, 3, 0, 3, 0, 1'b1, 1'b1);
    send_block(1'b0);
    finish_block("t3", 0);

    // Input gaps plus result backpressure
    set_pairs(200, 17, 5, 90, 33, 33, 128, 127, 1'b0, 1'b0);
    send_block(1'b1);
    finish_block("t4", 5);

    // Reset with a partial approximate block in flight
    bus.approx_en = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_a      = 8'd200;
    bus.in_b      = 8'd7;
    step();
    step();
    bus.in_valid = 1'b0;
    step();
    rst = 1'b1;
    #1;
    chk("t5.in_ready",  32'(bus.in_ready), 1);
    chk("t5.out_valid", 32'(bus.out_valid), 0);
    chk("t5.out_sad",   32'(bus.out_sad), 0);
    chk("t5.approx",    32'(bus.out_approx), 0);
    chk("t5.err",       32'(bus.out_err), 0);
    chk("t5.err_over",  32'(bus.out_err_over), 0);
    step();
    rst = 1'b0;
    step();
    set_pairs(1, 0, 1, 0, 1, 0, 1, 0, 1'b0, 1'b0);
    send_block(1'b0);
    finish_block("t5", 0);

    // Mode latched on the first beat only
    set_pairs(7, 0, 3, 1, 6, 4, 2, 3, 1'b1, 1'b0);
    send_block(1'b0);
    finish_block("t6", 0);

    // Random blocks
    for (int n = 0; n < 16; n++) begin
      for (int i = 0; i < BL; i++) begin
        ga[i] = 8'($urandom);
        gb[i] = 8'($urandom);
        gm[i] = 1'($urandom);
      end
      send_block(1'($urandom));
      finish_block($sformatf("rnd%0d", n), int'($urandom_range(2)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
